pkt_rr_arbiter: RTL and testbench
=================================

Name: pkt_rr_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one downstream packet queue between N_SRC AXI-stream sources.
- Each source carries 8-bit data, tlast and 8-bit mty, the same beat format the queue stores.
- A grant is held for a whole packet, from first beat to tlast, so packets never interleave in the queue.
- The output is fully registered and feeds the queue's s_axis_* inputs directly.

Parameters:
- N_SRC, 2: number of sources, 2..4.
- TIMEOUT_CYC, 256: stall limit in cycles (used only with PKT_TIMEOUT_EN).
- CNT_W, 32: width of the forwarded-packet counter.

Ports:
- aclk  input  1  clock
- areset  input  1  reset, synchronous, active-high
- s_axis_tvalid  input  N_SRC  per-source valid
- s_axis_tdata  input  8*N_SRC  per-source data; source i occupies [8i+7:8i]
- s_axis_tlast  input  N_SRC  per-source last
- s_axis_tuser_mty  input  8*N_SRC  per-source empty-byte count
- s_axis_tready  output  N_SRC  per-source ready
- m_axis_tvalid  output  1  to queue
- m_axis_tdata  output  8  to queue
- m_axis_tlast  output  1  to queue
- m_axis_tuser_mty  output  8  to queue
- m_axis_tready  input  1  from queue
- drop_incmpt_pkt  output  1  one-cycle pulse: the packet just terminated is incomplete
- grant_id  output  2  index of the currently or last granted source
- pkt_cnt  output  CNT_W  packets forwarded with a genuine tlast; wraps

Behaviour:
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tuser_mty=0, s_axis_tready=0, drop_incmpt_pkt=0, grant_id=0, pkt_cnt=0. State=IDLE, round-robin pointer=N_SRC-1, so source 0 has first priority.
- Output register may load when out_free = !m_axis_tvalid || m_axis_tready.
- s_axis_tready[i] = (state==PKT) && (grant_id==i) && out_free. In DRAIN it is 1 for grant_id. All other sources see 0.
- A beat is accepted when s_axis_tvalid[g] && s_axis_tready[g]. It is copied into the m_axis_* register on the next edge, giving 1-cycle latency.
- If m_axis_tready=1 and nothing new is accepted, m_axis_tvalid clears. The output holds stable while m_axis_tvalid && !m_axis_tready.
- IDLE state:
  - Search the sources in order ptr+1, ptr+2, ... modulo N_SRC for the first asserted s_axis_tvalid.
  - If one is found, register grant_id and go to PKT. No beat is accepted in this cycle, so there is one bubble per packet.
  - If none is found, stay in IDLE.
- PKT state:
  - Forward the granted source's beats.
  - On acceptance of a beat with tlast=1: pkt_cnt+1, ptr<=grant_id, go to IDLE.
  - A single-beat packet (tvalid with tlast on the first beat) is legal.
- DRAIN state (only with PKT_TIMEOUT_EN): discard the granted source's beats, never presenting them on m_axis_*. On a discarded beat with tlast=1: ptr<=grant_id, go to IDLE. pkt_cnt does not change.
- tvalid on non-granted sources has no effect until IDLE. Sources may drop tvalid mid-packet; the grant is kept.
- mty is passed through unmodified. No range check is done.
- Reset mid-packet:
  - Returns to IDLE, clears the output register and discards the in-flight partial packet.
  - Flushing the queue is not this block's responsibility.
- pkt_cnt wraps from 2^CNT_W-1 to 0.
- Round-robin order: with all sources requesting continuously and N_SRC=3, grant order is 0,1,2,0,...

Optional Feature:
- Macro PKT_TIMEOUT_EN.
- With the macro defined:
  - In PKT, a stall counter increments each cycle that s_axis_tvalid[grant_id]=0 and clears on any accepted beat.
  - When the counter reaches TIMEOUT_CYC, and out_free holds, the block loads the output with a terminator beat: tvalid=1, tdata=0, tlast=1, mty=0.
  - In the same cycle it pulses drop_incmpt_pkt=1 and goes to DRAIN.
  - The counter is held until out_free is true. DRAIN then lasts until the source's own tlast.
- With the macro undefined: no stall counter, no DRAIN state, drop_incmpt_pkt is tied to 0, and a stalled source holds the grant indefinitely.

Test Plan:
- Reset, then source0 sends a 4-beat packet 0x11..0x14 with mty=3 on the last beat, m_axis_tready=1 → m_axis beats 0x11..0x14 appear 2 cycles after first s_tvalid. tlast and mty=3 on 0x14. pkt_cnt=1.
- Sources 0 and 1 both continuously send 2-beat packets (N_SRC=2) → grant_id alternates 0,1,0,1; no interleaving; after 8 packets pkt_cnt=8.
- Source1 sends a 5-beat packet and m_axis_tready is toggled 1,0,0,1,... → every beat is delivered exactly once in order, and m_axis_* stays stable while tready=0.
- Source0 sends a 1-beat packet while source1 is mid-packet → the source0 beat appears only after source1's tlast beat.
- With PKT_TIMEOUT_EN and TIMEOUT_CYC=8, source0 sends 2 beats then idles 8 cycles, then sends 3 more ending in tlast:
  - A terminator beat (0x00, tlast, mty=0) appears with a drop_incmpt_pkt pulse.
  - The 3 late beats are consumed but not forwarded.
  - pkt_cnt is unchanged.
- Assert areset during beat 3 of a 6-beat packet → all outputs return to reset values. The next packet from source1 is forwarded cleanly, and grant starts at source 0 priority.

Source files
------------

// File: rtl/pkt_rr_arbiter.sv
// pkt_rr_arbiter: packet-granular round-robin arbiter sharing one AXI-stream queue between N_SRC sources.
// Define PKT_TIMEOUT_EN to truncate stalled packets with a terminator beat and drain the rest.
module pkt_rr_arbiter #(
    parameter int N_SRC       = 2,
    parameter int TIMEOUT_CYC = 256,
    parameter int CNT_W       = 32
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [N_SRC-1:0]     s_axis_tvalid,
    input  logic [8*N_SRC-1:0]   s_axis_tdata,
    input  logic [N_SRC-1:0]     s_axis_tlast,
    input  logic [8*N_SRC-1:0]   s_axis_tuser_mty,
    output logic [N_SRC-1:0]     s_axis_tready,
    output logic                 m_axis_tvalid,
    output logic [7:0]           m_axis_tdata,
    output logic                 m_axis_tlast,
    output logic [7:0]           m_axis_tuser_mty,
    input  logic                 m_axis_tready,
    output logic                 drop_incmpt_pkt,
    output logic [1:0]           grant_id,
    output logic [CNT_W-1:0]     pkt_cnt
);
    localparam int GW = (N_SRC > 2) ? 2 : 1;
    typedef enum logic [1:0] {IDLE, PKT, DRAIN} state_t;
    state_t          state_q;
    logic [GW-1:0]   grant_q, ptr_q, pick;
    logic            found, out_free, sel_vld, sel_last, acc, tmo;
    logic [7:0]      sel_data, sel_mty;
    logic            m_valid_q, m_last_q;
    logic [7:0]      m_data_q, m_mty_q;
    logic [CNT_W-1:0] cnt_q;
    assign out_free = !m_valid_q || m_axis_tready;
    assign sel_vld  = s_axis_tvalid[grant_q];
    assign sel_last = s_axis_tlast[grant_q];
    assign sel_data = s_axis_tdata[{grant_q, 3'b000} +: 8];
    assign sel_mty  = s_axis_tuser_mty[{grant_q, 3'b000} +: 8];
`ifdef PKT_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYC + 1);
    logic [SW-1:0] stall_q;
    logic          drop_q;
    assign tmo = (stall_q == SW'(TIMEOUT_CYC));
    assign drop_incmpt_pkt = drop_q;
`else
    assign tmo = 1'b0;
    assign drop_incmpt_pkt = 1'b0;
`endif
    assign acc = (state_q == PKT) && !tmo && out_free && sel_vld;
    assign s_axis_tready = (((state_q == PKT) && out_free && !tmo) || (state_q == DRAIN))
                         ? (N_SRC'(1) << grant_q) : '0;
    // Later loop iterations are closer to ptr, so the last hit wins.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        for (int k = N_SRC; k >= 1; k--) begin
            if (s_axis_tvalid[GW'((int'(ptr_q) + k) % N_SRC)]) begin
                found = 1'b1;
                pick  = GW'((int'(ptr_q) + k) % N_SRC);
            end
        end
    end
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= GW'(N_SRC - 1);
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_last_q  <= 1'b0;
            m_mty_q   <= '0;
            cnt_q     <= '0;
`ifdef PKT_TIMEOUT_EN
            stall_q   <= '0;
            drop_q    <= 1'b0;
`endif
        end else begin
            if (out_free) m_valid_q <= 1'b0;
`ifdef PKT_TIMEOUT_EN
            drop_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (found) begin
                        grant_q <= pick;
                        state_q <= PKT;
`ifdef PKT_TIMEOUT_EN
                        stall_q <= '0;
`endif
                    end
                end
                PKT: begin
                    if (acc) begin
                        m_valid_q <= 1'b1;
                        m_data_q  <= sel_data;
                        m_last_q  <= sel_last;
                        m_mty_q   <= sel_mty;
`ifdef PKT_TIMEOUT_EN
                        stall_q   <= '0;
`endif
                        if (sel_last) begin
                            cnt_q   <= cnt_q + CNT_W'(1);
                            ptr_q   <= grant_q;
                            state_q <= IDLE;
                        end
                    end
`ifdef PKT_TIMEOUT_EN
                    else if (tmo) begin
                        if (out_free) begin
                            m_valid_q <= 1'b1;
                            m_data_q  <= '0;
                            m_last_q  <= 1'b1;
                            m_mty_q   <= '0;
                            drop_q    <= 1'b1;
                            state_q   <= DRAIN;
                        end
                    end else if (!sel_vld) begin
                        stall_q <= stall_q + SW'(1);
                    end
                end
                DRAIN: begin
                    if (sel_vld && sel_last) begin
                        ptr_q   <= grant_q;
                        state_q <= IDLE;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign m_axis_tvalid    = m_valid_q;
    assign m_axis_tdata     = m_data_q;
    assign m_axis_tlast     = m_last_q;
    assign m_axis_tuser_mty = m_mty_q;
    assign grant_id         = 2'(grant_q);
    assign pkt_cnt          = cnt_q;
endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// tb_pkt_rr_arbiter: directed plus randomized checks of pkt_rr_arbiter against a packet-level model.
module tb_pkt_rr_arbiter;
    localparam int N = 2, TMO = 8, CW = 4;
    logic            aclk = 1'b0, areset = 1'b1;
    logic [N-1:0]    s_tvalid, s_tlast, s_tready;
    logic [8*N-1:0]  s_tdata, s_mty;
    logic            m_tvalid, m_tlast, m_tready, drop;
    logic [7:0]      m_tdata, m_mty;
    logic [1:0]      gid;
    logic [CW-1:0]   pcnt;
    always #5 aclk = ~aclk;
    pkt_rr_arbiter #(.N_SRC(N), .TIMEOUT_CYC(TMO), .CNT_W(CW)) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata), .s_axis_tlast(s_tlast),
        .s_axis_tuser_mty(s_mty), .s_axis_tready(s_tready),
        .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata), .m_axis_tlast(m_tlast),
        .m_axis_tuser_mty(m_mty), .m_axis_tready(m_tready),
        .drop_incmpt_pkt(drop), .grant_id(gid), .pkt_cnt(pcnt)
    );
    typedef struct packed {logic [7:0] d; logic l; logic [7:0] m;} beat_t;
    beat_t src_q[N][$];
    beat_t sent_q[N][$];
    beat_t out_log[$];
    int    out_cyc[$];
    int    vectors = 0, miscompares = 0, cyc = 0, drops = 0, drop_term = 0;
    int    cur_src = -1, exp_pkts = 0, gap_pct = 0, rdy_mode = 0;
    bit    chk_en = 1'b1, prev_stall = 1'b0;
    bit    acc[N];
    beat_t prev;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic push(input int s, input logic [7:0] d, input logic l, input logic [7:0] m);
        src_q[s].push_back({d, l, m});
    endtask
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0 && $urandom_range(99) >= gap_pct) begin
                s_tvalid[i]      = 1'b1;
                s_tdata[8*i +: 8] = src_q[i][0].d;
                s_tlast[i]       = src_q[i][0].l;
                s_mty[8*i +: 8]  = src_q[i][0].m;
            end else begin
                s_tvalid[i]      = 1'b0;
                s_tdata[8*i +: 8] = 8'h00;
                s_tlast[i]       = 1'b0;
                s_mty[8*i +: 8]  = 8'h00;
            end
        end
        m_tready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (cyc % 3 == 0) : ($urandom_range(99) < 70);
    endtask
    function automatic bit busy();
        bit b = m_tvalid || (cur_src >= 0);
        for (int i = 0; i < N; i++) b |= (src_q[i].size() > 0);
        return b;
    endfunction
    // Sample at the falling edge, advance one clock, then retire handshakes and redrive.
    task automatic tick();
        beat_t b, e;
        @(negedge aclk);
        for (int i = 0; i < N; i++) acc[i] = s_tvalid[i] && s_tready[i];
        b = {m_tdata, m_tlast, m_mty};
        if (!areset) begin
            if (prev_stall) chk("hold", {m_tvalid, b}, {1'b1, prev});
            chk("rdy_onehot", 32'($countones(s_tready) <= 1), 1);
            if (drop) begin
                drops++;
                if (m_tvalid && b == {8'h00, 1'b1, 8'h00}) drop_term++;
            end
            if (m_tvalid && m_tready) begin
                out_log.push_back(b);
                out_cyc.push_back(cyc);
                if (chk_en) begin
                    if (cur_src < 0) cur_src = int'(m_tdata[7:6]) % N;
                    chk("beat_owed", 32'(sent_q[cur_src].size() > 0), 1);
                    if (sent_q[cur_src].size() > 0) begin
                        e = sent_q[cur_src].pop_front();
                        chk("beat", 32'(b), 32'(e));
                    end
                    if (m_tlast) begin
                        cur_src = -1;
                        exp_pkts++;
                    end
                end
            end
        end
        prev_stall = !areset && m_tvalid && !m_tready;
        prev = b;
        @(posedge aclk);
        cyc++;
        #1;
        if (!areset) for (int i = 0; i < N; i++) if (acc[i]) sent_q[i].push_back(src_q[i].pop_front());
        drive();
    endtask
    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (busy() && n < budget);
        chk({tag, "_idle"}, 32'(busy()), 0);
    endtask
    task automatic do_reset();
        areset = 1'b1;
        tick();
        for (int i = 0; i < N; i++) begin
            src_q[i].delete();
            sent_q[i].delete();
        end
        drive();
        tick();
        areset = 1'b0;
        cur_src = -1;
        exp_pkts = 0;
        prev_stall = 1'b0;
    endtask
    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mvalid"}, 32'(m_tvalid), 0);
        chk({tag, "_mdata"}, 32'(m_tdata), 0);
        chk({tag, "_mlast"}, 32'(m_tlast), 0);
        chk({tag, "_mmty"}, 32'(m_mty), 0);
        chk({tag, "_sready"}, 32'(s_tready), 0);
        chk({tag, "_drop"}, 32'(drop), 0);
        chk({tag, "_grant"}, 32'(gid), 0);
        chk({tag, "_pcnt"}, 32'(pcnt), 0);
    endtask
    initial begin
        int t0, len;
        logic [CW-1:0] c_before;
        s_tvalid = '0; s_tdata = '0; s_tlast = '0; s_mty = '0; m_tready = 1'b1;
        do_reset();
        chk_reset_outputs("rst");
        // One 4-beat packet, full rate downstream.
        out_log.delete(); out_cyc.delete();
        for (int k = 0; k < 4; k++) push(0, 8'h11 + 8'(k), k == 3, (k == 3) ? 8'd3 : 8'd0);
        tick();
        t0 = cyc;
        wait_idle(100, "t1");
        chk("t1_nbeats", out_log.size(), 4);
        for (int k = 0; k < 4 && k < out_log.size(); k++)
            chk("t1_beat", 32'(out_log[k]), 32'({8'h11 + 8'(k), k == 3, (k == 3) ? 8'd3 : 8'd0}));
        if (out_cyc.size() == 4) begin
            chk("t1_latency", out_cyc[0] - t0, 2);
            chk("t1_back2back", out_cyc[3] - out_cyc[0], 3);
        end
        chk("t1_pcnt", 32'(pcnt), 1);
        // Two saturated sources alternate packet by packet.
        do_reset();
        out_log.delete();
        for (int p = 0; p < 4; p++)
            for (int s = 0; s < 2; s++)
                for (int b = 0; b < 2; b++) push(s, {2'(s), 6'(p * 2 + b)}, b == 1, 8'(p));
        wait_idle(200, "t2");
        chk("t2_nbeats", out_log.size(), 16);
        for (int k = 0; k < 8 && 2 * k + 1 < out_log.size(); k++) begin
            chk("t2_src_first", 32'(out_log[2*k].d[7:6]), k % 2);
            chk("t2_src_second", 32'(out_log[2*k+1].d[7:6]), k % 2);
        end
        chk("t2_pcnt", 32'(pcnt), 8);
        // Downstream backpressure 1,0,0 repeating.
        out_log.delete();
        rdy_mode = 1;
        for (int k = 0; k < 5; k++) push(1, 8'h41 + 8'(k), k == 4, (k == 4) ? 8'd7 : 8'd0);
        wait_idle(200, "t3");
        rdy_mode = 0;
        chk("t3_nbeats", out_log.size(), 5);
        for (int k = 0; k < 5 && k < out_log.size(); k++) chk("t3_data", 32'(out_log[k].d), 32'(8'h41 + 8'(k)));
        chk("t3_pcnt", 32'(pcnt), 9);
        // A single-beat packet from source 0 waits behind source 1's packet.
        out_log.delete();
        for (int k = 0; k < 4; k++) push(1, 8'h51 + 8'(k), k == 3, 8'd0);
        repeat (3) tick();
        push(0, 8'h21, 1'b1, 8'd5);
        wait_idle(100, "t4");
        chk("t4_nbeats", out_log.size(), 5);
        if (out_log.size() == 5) begin
            chk("t4_src1_tail", 32'(out_log[3]), 32'({8'h54, 1'b1, 8'd0}));
            chk("t4_src0_after", 32'(out_log[4]), 32'({8'h21, 1'b1, 8'd5}));
        end
`ifdef PKT_TIMEOUT_EN
        // Stalled packet is terminated, its late beats drained.
        out_log.delete();
        chk_en = 1'b0;
        drops = 0; drop_term = 0;
        c_before = pcnt;
        push(0, 8'hA1, 1'b0, 8'd0);
        push(0, 8'hA2, 1'b0, 8'd0);
        for (int n = 0; n < 50 && src_q[0].size() > 0; n++) tick();
        repeat (TMO) tick();
        push(0, 8'hA3, 1'b0, 8'd0);
        push(0, 8'hA4, 1'b0, 8'd0);
        push(0, 8'hA5, 1'b1, 8'd2);
        wait_idle(100, "t5");
        chk("t5_nbeats", out_log.size(), 3);
        if (out_log.size() == 3) begin
            chk("t5_b0", 32'(out_log[0].d), 32'h A1);
            chk("t5_b1", 32'(out_log[1].d), 32'h A2);
            chk("t5_term", 32'(out_log[2]), 32'({8'h00, 1'b1, 8'h00}));
        end
        chk("t5_drops", drops, 1);
        chk("t5_drop_with_term", drop_term, 1);
        chk("t5_pcnt", 32'(pcnt), 32'(c_before));
        sent_q[0].delete();
        chk_en = 1'b1;
`endif
        // Reset in the middle of a packet.
        for (int k = 0; k < 6; k++) push(0, 8'h31 + 8'(k), k == 5, 8'd0);
        for (int n = 0; n < 50 && sent_q[0].size() < 2; n++) tick();
        do_reset();
        chk_reset_outputs("midrst");
        out_log.delete();
        for (int k = 0; k < 3; k++) push(1, 8'h61 + 8'(k), k == 2, (k == 2) ? 8'd1 : 8'd0);
        push(0, 8'h0A, 1'b0, 8'd0);
        push(0, 8'h0B, 1'b1, 8'd4);
        wait_idle(100, "t6");
        chk("t6_nbeats", out_log.size(), 5);
        if (out_log.size() == 5) begin
            chk("t6_src0_first", 32'(out_log[0].d), 32'h0A);
            chk("t6_src1_clean", 32'(out_log[2].d), 32'h61);
        end
        chk("t6_pcnt", 32'(pcnt), 2);
        // Random traffic with random gaps and backpressure; pkt_cnt wraps past 15.
`ifdef PKT_TIMEOUT_EN
        gap_pct = 0;
`else
        gap_pct = 25;
`endif
        rdy_mode = 2;
        for (int p = 0; p < 20; p++)
            for (int s = 0; s < N; s++) begin
                len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++)
                    push(s, {2'(s), 6'($urandom)}, b == len - 1, (b == len - 1) ? 8'($urandom) : 8'd0);
            end
        wait_idle(3000, "t7");
        rdy_mode = 0;
        gap_pct = 0;
        chk("t7_pkts", exp_pkts, 42);
        chk("t7_pcnt_wrap", 32'(pcnt), exp_pkts % (1 << CW));
        for (int s = 0; s < N; s++) chk("t7_leftover", sent_q[s].size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1);
    end
endmodule
